// File: rtl/movegen_pkg.sv
// Shared constants and FSM state type for the move-generator scheduler.
package movegen_pkg;

    localparam int unsigned BOARD_BYTES = 256;

    localparam int unsigned PIECE_PAWN   = 1;
    localparam int unsigned PIECE_KNIGHT = 2;
    localparam int unsigned PIECE_BISHOP = 3;
    localparam int unsigned PIECE_ROOK   = 4;
    localparam int unsigned PIECE_QUEEN  = 5;
    localparam int unsigned PIECE_KING   = 6;

    // CPU-visible register indices
    localparam logic [3:0] REG_START  = 4'd0;
    localparam logic [3:0] REG_SRC    = 4'd1;
    localparam logic [3:0] REG_DST    = 4'd2;
    localparam logic [3:0] REG_MAX    = 4'd3;
    localparam logic [3:0] REG_CYCLES = 4'd6;

    // Generator register indices; index 0 is GO on write and RESULT on read
    localparam logic [3:0] GEN_REG_CTRL = 4'd0;
    localparam logic [3:0] GEN_REG_SRC  = 4'd1;
    localparam logic [3:0] GEN_REG_DST  = 4'd2;
    localparam logic [3:0] GEN_REG_X    = 4'd3;
    localparam logic [3:0] GEN_REG_Y    = 4'd4;

    typedef enum logic [3:0] {
        StIdle,
        StScanRd,
        StScanWait,
        StDecode,
        StGSrc,
        StGDst,
        StGX,
        StGY,
        StGGo,
        StGResult,
        StAdvance,
        StDone
    } state_e;

endpackage

// File: rtl/movegen_bus_port.sv
// Generator-bus access port: drives one access while req is held, pulses done
// on the accepting cycle and captures read data at that point.
module movegen_bus_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic [3:0]  gen_address,
    output logic        gen_read,
    output logic        gen_write,
    output logic [31:0] gen_writedata,
    input  logic [31:0] gen_readdata,
    input  logic        gen_waitrequest
);

    logic [31:0] rdata_q;

    always_comb begin
        gen_address   = req ? addr : 4'd0;
        gen_write     = req && wr;
        gen_read      = req && !wr;
        gen_writedata = (req && wr) ? wdata : 32'd0;
        done          = req && !gen_waitrequest;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if (done && !wr) begin
            rdata_q <= gen_readdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/movegen_scheduler.sv
// Scans a source board and dispatches each own-colour piece to its generator.
// Optional cycle counter at CPU address 6 is built when SCHED_CYCLE_COUNT_EN is defined.
module movegen_scheduler
    import movegen_pkg::*;
#(
    parameter int unsigned NUM_GEN        = PIECE_KING,
    parameter int unsigned GEN_MAX_BOARDS = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               slave_waitrequest,
    input  logic [3:0]         slave_address,
    input  logic               slave_read,
    output logic [31:0]        slave_readdata,
    input  logic               slave_write,
    input  logic [31:0]        slave_writedata,
    input  logic               master_waitrequest,
    output logic [31:0]        master_address,
    output logic               master_read,
    input  logic [31:0]        master_readdata,
    input  logic               master_readdatavalid,
    output logic [NUM_GEN-1:0] gen_sel,
    output logic [3:0]         gen_address,
    output logic               gen_read,
    output logic               gen_write,
    output logic [31:0]        gen_writedata,
    input  logic [31:0]        gen_readdata,
    input  logic               gen_waitrequest
);

    state_e state_q, state_d;

    logic [5:0]         sq_q;
    logic [7:0]         pc_q;
    logic [31:0]        total_q, cursor_q, src_q, dst_q, max_q;
    logic               overflow_q, colour_q, acc_pend_q;
    logic [NUM_GEN-1:0] gen_sel_q;

    logic        busy, start_wr, cfg_wr, rd_result;
    logic [7:0]  mag;
    logic        skip, no_room;
    logic        bus_req, bus_wr, bus_done;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic [31:0] cycles_rd;
    logic        unused_bits;

    assign busy      = !(state_q == StIdle || state_q == StDone);
    assign start_wr  = slave_write && (slave_address == REG_START) && (state_q == StIdle);
    assign cfg_wr    = slave_write && (state_q == StIdle || state_q == StDone);
    assign rd_result = slave_read && (slave_address == REG_START);

    // -128 maps to 128, which is simply out of range
    assign mag     = pc_q[7] ? (8'd0 - pc_q) : pc_q;
    assign skip    = (pc_q == 8'd0) || (pc_q[7] != colour_q) || (32'(mag) > NUM_GEN);
    assign no_room = (max_q - total_q) < GEN_MAX_BOARDS;

    assign unused_bits = ^{master_readdata[31:8], total_q[31]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (start_wr) state_d = StScanRd;
            StScanRd:   if (!master_waitrequest) state_d = StScanWait;
            StScanWait: if (master_readdatavalid) state_d = StDecode;
            StDecode: begin
                if (skip)         state_d = StAdvance;
                else if (no_room) state_d = StDone;
                else              state_d = StGSrc;
            end
            StGSrc:     if (bus_done) state_d = StGDst;
            StGDst:     if (bus_done) state_d = StGX;
            StGX:       if (bus_done) state_d = StGY;
            StGY:       if (bus_done) state_d = StGGo;
            StGGo:      if (bus_done) state_d = StGResult;
            StGResult:  if (bus_done) state_d = StAdvance;
            StAdvance:  state_d = (sq_q == 6'd63) ? StDone : StScanRd;
            StDone:     if (rd_result) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        master_read    = 1'b0;
        master_address = 32'd0;
        bus_req        = 1'b0;
        bus_wr         = 1'b1;
        bus_addr       = 4'd0;
        bus_wdata      = 32'd0;
        case (state_q)
            StScanRd: begin
                master_read    = 1'b1;
                master_address = src_q + {24'd0, sq_q, 2'b00};
            end
            StGSrc: begin
                bus_req   = 1'b1;
                bus_addr  = GEN_REG_SRC;
                bus_wdata = src_q;
            end
            StGDst: begin
                bus_req   = 1'b1;
                bus_addr  = GEN_REG_DST;
                bus_wdata = cursor_q;
            end
            StGX: begin
                bus_req   = 1'b1;
                bus_addr  = GEN_REG_X;
                bus_wdata = {29'd0, sq_q[2:0]};
            end
            StGY: begin
                bus_req   = 1'b1;
                bus_addr  = GEN_REG_Y;
                bus_wdata = {29'd0, sq_q[5:3]};
            end
            StGGo: begin
                bus_req   = 1'b1;
                bus_addr  = GEN_REG_CTRL;
                bus_wdata = 32'd1;
            end
            StGResult: begin
                bus_req  = 1'b1;
                bus_wr   = 1'b0;
                bus_addr = GEN_REG_CTRL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_q       <= 6'd0;
            pc_q       <= 8'd0;
            total_q    <= 32'd0;
            cursor_q   <= 32'd0;
            src_q      <= 32'd0;
            dst_q      <= 32'd0;
            max_q      <= 32'd0;
            overflow_q <= 1'b0;
            colour_q   <= 1'b0;
            acc_pend_q <= 1'b0;
            gen_sel_q  <= '0;
        end else begin
            if (cfg_wr) begin
                case (slave_address)
                    REG_SRC: src_q <= slave_writedata;
                    REG_DST: dst_q <= slave_writedata;
                    REG_MAX: max_q <= slave_writedata;
                    default: ;
                endcase
            end
            case (state_q)
                StIdle: begin
                    if (start_wr) begin
                        sq_q       <= 6'd0;
                        total_q    <= 32'd0;
                        overflow_q <= 1'b0;
                        acc_pend_q <= 1'b0;
                        cursor_q   <= dst_q;
                        colour_q   <= slave_writedata[0];
                    end
                end
                StScanWait: if (master_readdatavalid) pc_q <= master_readdata[7:0];
                StDecode: begin
                    if (!skip) begin
                        if (no_room) overflow_q <= 1'b1;
                        else         gen_sel_q  <= NUM_GEN'(1) << (mag - 8'd1);
                    end
                end
                StGResult: begin
                    if (bus_done) begin
                        gen_sel_q  <= '0;
                        acc_pend_q <= 1'b1;
                    end
                end
                StAdvance: begin
                    // Count captured on accept is folded in here, one cycle later
                    if (acc_pend_q) begin
                        total_q    <= total_q + bus_rdata;
                        cursor_q   <= cursor_q + bus_rdata * BOARD_BYTES;
                        acc_pend_q <= 1'b0;
                    end
                    if (sq_q != 6'd63) sq_q <= sq_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef SCHED_CYCLE_COUNT_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= 32'd0;
        end else if (start_wr) begin
            cycles_q <= 32'd0;
        end else if (busy && cycles_q != 32'hFFFF_FFFF) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign cycles_rd = cycles_q;
`else
    assign cycles_rd = 32'd0;
`endif

    always_comb begin
        slave_waitrequest = rd_result && busy;
        case (slave_address)
            REG_START:  slave_readdata = busy ? 32'd0 : {overflow_q, total_q[30:0]};
            REG_CYCLES: slave_readdata = cycles_rd;
            default:    slave_readdata = 32'd0;
        endcase
    end

    assign gen_sel = gen_sel_q;

    movegen_bus_port u_bus_port (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (bus_req),
        .wr              (bus_wr),
        .addr            (bus_addr),
        .wdata           (bus_wdata),
        .done            (bus_done),
        .rdata           (bus_rdata),
        .gen_address     (gen_address),
        .gen_read        (gen_read),
        .gen_write       (gen_write),
        .gen_writedata   (gen_writedata),
        .gen_readdata    (gen_readdata),
        .gen_waitrequest (gen_waitrequest)
    );

endmodule
